// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned ITER    = 32;
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     opnd,
    output logic [2*WIDTH-1:0]   acc_next_c
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;

    always_comb begin
        sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        // Upper half shifted left by one, with the dividend MSB brought in.
        trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
        acc_next_c = {sum, acc[WIDTH-1:1]};
        if (is_div) begin
            if (trial[WIDTH]) begin
                acc_next_c = {acc[2*WIDTH-2:0], 1'b0};
            end else begin
                acc_next_c = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative mult/multu/div/divu with architectural HI/LO; busy stalls the pipeline.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = muldiv_pkg::ITER
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    import muldiv_pkg::*;

    localparam int unsigned CW = $clog2(ITER);

    state_e               state;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]     opnd;
    logic [WIDTH-1:0]     a_orig;
    logic                 is_div;
    logic                 neg_res;
    logic                 neg_rem;
    logic                 b_zero;

    logic                 sgn;
    logic                 op_div;
    logic [WIDTH-1:0]     a_abs;
    logic [WIDTH-1:0]     b_abs;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div     (is_div),
        .acc        (acc),
        .opnd       (opnd),
        .acc_next_c (acc_next)
    );

    // Operand magnitudes at issue and sign fix-up of the final iteration.
    always_comb begin
        sgn      = (op == OP_MULT) || (op == OP_DIV);
        op_div   = (op == OP_DIV) || (op == OP_DIVU);
        a_abs    = (sgn && a[WIDTH-1]) ? -a : a;
        b_abs    = (sgn && b[WIDTH-1]) ? -b : b;
        prod_fix = neg_res ? -acc_next : acc_next;
        quo_fix  = neg_res ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
        rem_fix  = neg_rem ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            a_orig  <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            b_zero  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start && !flush) begin
                        state   <= CALC;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        is_div  <= op_div;
                        neg_res <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem <= sgn && a[WIDTH-1];
                        b_zero  <= (b == '0);
                        a_orig  <= a;
                        acc     <= {{WIDTH{1'b0}}, (op_div ? a_abs : b_abs)};
                        opnd    <= op_div ? b_abs : a_abs;
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(ITER - 1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                            if (!is_div) begin
                                hi <= prod_fix[2*WIDTH-1:WIDTH];
                                lo <= prod_fix[WIDTH-1:0];
                            end else if (b_zero) begin
                                hi <= a_orig;
                                lo <= WIDTH'(DIV0_LO);
                            end else begin
                                hi <= rem_fix;
                                lo <= quo_fix;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: transaction-level reference model plus directed literal checks.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Architectural result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: begin p = 64'(sx * sy); return p; end
            2'b01: return {32'b0, x} * {32'b0, y};
            2'b10: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                p = {r[31:0], q[31:0]};
                return p;
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Model: m_rem = cycles left until the unit is idle again (33 after accept).
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int          m_rem = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi = '0; m_lo = '0; m_rem = 0;
        end else if (m_rem == 0) begin
            if (hi_we) m_hi = wdata;
            if (lo_we) m_lo = wdata;
            if (start && !flush) begin
                {p_hi, p_lo} = ref_res(op, a, b);
                m_rem = 33;
            end
        end else if (m_rem >= 2 && flush) begin
            m_rem = 0;
        end else begin
            if (m_rem == 2) begin m_hi = p_hi; m_lo = p_lo; end
            m_rem = m_rem - 1;
        end
    end

    always @(negedge clk) begin
        check("busy", 64'(busy), 64'(m_rem != 0));
        check("done", 64'(done), 64'(m_rem == 1));
        check("hi", 64'(hi), 64'(m_hi));
        check("lo", 64'(lo), 64'(m_lo));
    end

    // Issue one op, wait for done, check latency and literal results.
    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        int nbusy;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        nbusy = busy ? 1 : 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (busy) nbusy++;
        end
        check({nm, "_latency"}, 64'(n), 64'd33);
        check({nm, "_hi"}, 64'(hi), 64'(ehi));
        check({nm, "_lo"}, 64'(lo), 64'(elo));
        @(negedge clk);
        check({nm, "_busycycles"}, 64'(nbusy), 64'd33);
        check({nm, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int ndone;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);

        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", 2'b11, 32'd7, 32'd2, 32'd1, 32'd3);
        run_op("divu_zero", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

        // Preload HI/LO, then flush a multiply mid-flight; a start during busy is ignored.
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("preload_hi", 64'(hi), 64'h1234_5678);
        check("preload_lo", 64'(lo), 64'h1234_5678);
        start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin @(negedge clk); if (done) ndone++; end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_hi", 64'(hi), 64'h1234_5678);
        check("flush_lo", 64'(lo), 64'h1234_5678);
        repeat (30) begin @(negedge clk); if (done) ndone++; end
        check("flush_nodone", 64'(ndone), 64'd0);

        // Asynchronous reset mid-CALC.
        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'hCAFE_0001;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi_hi", 64'(hi), 64'hCAFE_0001);
        check("mthi_lo", 64'(lo), 64'd0);

        // Random traffic; the model and compare process judge every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 99) == 0);
            hi_we = ($urandom_range(0, 7) == 0);
            lo_we = ($urandom_range(0, 7) == 0);
            wdata = $urandom;
            op    = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: a = 32'h8000_0000;
                1: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
        end
        @(negedge clk);
        start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
